// File: rtl/fp_calc_pkg.sv
// Shared types and constants for the keypad-driven fp adder sequencer.
package fp_calc_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTER_A = 3'd1,
        S_ENTER_B = 3'd2,
        S_ISSUE   = 3'd3,
        S_WAIT    = 3'd4,
        S_SHOW    = 3'd5,
        S_ERR     = 3'd6
    } state_e;

    localparam logic [3:0]  KEY_CLEAR = 4'd12;
    localparam logic [3:0]  KEY_ENTER = 4'd14;
    localparam logic [15:0] DISP_ERR  = 16'hEEEE;

    // Classified keypad press
    typedef struct packed {
        logic       is_digit;
        logic       is_clear;
        logic       is_enter;
        logic [3:0] digit;
    } key_t;

endpackage

// File: rtl/fp_calc_sequencer_if.sv
// Keypad, adder and display signals of the sequencer, bundled as one bus.
// slave = sequencer side, master = environment (keypad scanner + adder).
interface fp_calc_sequencer_if;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] res_in;
    logic        res_valid;
    logic        res_ovf;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        start;
    logic        busy;
    logic        done;
    logic        err;
    logic        ovf;
    logic [2:0]  state_led;
    logic [2:0]  digit_cnt;
    logic [15:0] disp_value;

    modport slave (
        input  key_valid, key_code, res_in, res_valid, res_ovf,
        output op_a, op_b, start, busy, done, err, ovf, state_led, digit_cnt, disp_value
    );

    modport master (
        output key_valid, key_code, res_in, res_valid, res_ovf,
        input  op_a, op_b, start, busy, done, err, ovf, state_led, digit_cnt, disp_value
    );
endinterface

// File: rtl/fp_key_decode.sv
// Maps a raw keypad scan index onto a hex digit or a CLEAR/ENTER command.
module fp_key_decode
    import fp_calc_pkg::*;
(
    input  logic [3:0] key_code_i,
    output key_t       key_o
);

    // Keypad layout: columns 1-2-3-A / 4-5-6-B / 7-8-9-C / *-0-#-D
    always_comb begin
        key_o          = '0;
        key_o.is_digit = 1'b1;
        case (key_code_i)
            4'd0:    key_o.digit = 4'h1;
            4'd1:    key_o.digit = 4'h2;
            4'd2:    key_o.digit = 4'h3;
            4'd3:    key_o.digit = 4'hA;
            4'd4:    key_o.digit = 4'h4;
            4'd5:    key_o.digit = 4'h5;
            4'd6:    key_o.digit = 4'h6;
            4'd7:    key_o.digit = 4'hB;
            4'd8:    key_o.digit = 4'h7;
            4'd9:    key_o.digit = 4'h8;
            4'd10:   key_o.digit = 4'h9;
            4'd11:   key_o.digit = 4'hC;
            4'd13:   key_o.digit = 4'h0;
            4'd15:   key_o.digit = 4'hD;
            default: key_o.is_digit = 1'b0;
        endcase
        key_o.is_clear = (key_code_i == KEY_CLEAR);
        key_o.is_enter = (key_code_i == KEY_ENTER);
    end

endmodule

// File: rtl/fp_calc_sequencer.sv
// Keypad operation sequencer for the half-precision adder: collects two
// 4-digit hex operands, issues one add, waits for the result and holds it
// for the display. Optional macro FP_CALC_CHAIN_EN: ENTER in SHOW loads the
// result into operand A and continues at operand B (accumulator chaining)
// instead of reissuing the same operands.
module fp_calc_sequencer
    import fp_calc_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int DIGITS  = 4
) (
    input  logic                clk,
    input  logic                reset,
    fp_calc_sequencer_if.slave  bus
);

    localparam int         TW      = $clog2(TIMEOUT + 1);
    localparam logic [2:0] CNT_MAX = 3'(DIGITS);

    state_e      state_q, state_d;
    logic        key_q;
    logic [15:0] op_a_q, op_a_d;
    logic [15:0] op_b_q, op_b_d;
    logic [15:0] res_q, res_d;
    logic [15:0] disp_q, disp_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic        ovf_q, ovf_d;

    key_t        kd;
    logic        key_ev;
    logic [2:0]  cnt_inc;

    fp_key_decode u_dec (
        .key_code_i (bus.key_code),
        .key_o      (kd)
    );

    // One event per press: rising edge of the level key flag
    assign key_ev  = bus.key_valid & ~key_q;
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 3'd1;

    // State, operand, result and display registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            key_q   <= 1'b0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            res_q   <= '0;
            disp_q  <= '0;
            cnt_q   <= '0;
            timer_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= bus.key_valid;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            res_q   <= res_d;
            disp_q  <= disp_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state, operand entry and display selection
    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        timer_d = timer_q;
        ovf_d   = ovf_q;
        disp_d  = '0;

        case (state_q)
            S_IDLE: begin
                op_a_d  = '0;
                op_b_d  = '0;
                cnt_d   = '0;
                state_d = S_ENTER_A;
            end
            S_ENTER_A: if (key_ev) begin
                if (kd.is_digit) begin
                    op_a_d = {op_a_q[11:0], kd.digit};
                    cnt_d  = cnt_inc;
                end else if (kd.is_clear) begin
                    op_a_d = '0;
                    cnt_d  = '0;
                end else if (kd.is_enter && cnt_q != '0) begin
                    cnt_d   = '0;
                    state_d = S_ENTER_B;
                end
            end
            S_ENTER_B: if (key_ev) begin
                if (kd.is_digit) begin
                    op_b_d = {op_b_q[11:0], kd.digit};
                    cnt_d  = cnt_inc;
                end else if (kd.is_clear) begin
                    // CLEAR on an empty B steps back to A with A intact
                    if (cnt_q == '0) begin
                        cnt_d   = CNT_MAX;
                        state_d = S_ENTER_A;
                    end else begin
                        op_b_d = '0;
                        cnt_d  = '0;
                    end
                end else if (kd.is_enter && cnt_q != '0) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A result arriving on the timeout cycle still counts
                if (bus.res_valid) begin
                    res_d   = bus.res_in;
                    ovf_d   = bus.res_ovf;
                    state_d = S_SHOW;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    state_d = S_ERR;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_SHOW: if (key_ev) begin
                if (kd.is_digit) begin
                    op_a_d  = {12'h000, kd.digit};
                    op_b_d  = '0;
                    cnt_d   = 3'd1;
                    state_d = S_ENTER_A;
                end else if (kd.is_enter) begin
`ifdef FP_CALC_CHAIN_EN
                    op_a_d  = res_q;
                    op_b_d  = '0;
                    cnt_d   = '0;
                    state_d = S_ENTER_B;
`else
                    state_d = S_ISSUE;
`endif
                end else if (kd.is_clear) begin
                    ovf_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_ERR: if (key_ev && kd.is_clear) begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_ENTER_A: disp_d = op_a_d;
            S_ENTER_B: disp_d = op_b_d;
            S_SHOW:    disp_d = res_d;
            S_ERR:     disp_d = DISP_ERR;
            default:   disp_d = '0;
        endcase
    end

    assign bus.op_a       = op_a_q;
    assign bus.op_b       = op_b_q;
    assign bus.start      = (state_q == S_ISSUE);
    assign bus.busy       = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign bus.done       = (state_q == S_SHOW);
    assign bus.err        = (state_q == S_ERR);
    assign bus.ovf        = ovf_q;
    assign bus.state_led  = state_q;
    assign bus.digit_cnt  = cnt_q;
    assign bus.disp_value = disp_q;

endmodule
